// File: rtl/spi_slave_regfile.sv
// SPI mode-0 slave in front of a small 32-bit register file.
// Frame: 1 write flag, 8 address bits, 32 data bits, MSB first.
// All SPI inputs are synchronized into SCLK before any edge is detected.
module spi_slave_regfile #(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_REGS    = 16,
  localparam int AW         = $clog2(NUM_REGS)
) (
  input  logic          SCLK,
  input  logic          SRESETn,
  input  logic          spi_clk,
  input  logic          spi_cs,
  input  logic          spi_mosi,
  output logic          spi_miso,
  input  logic [AW-1:0] reg_rd_addr,
  output logic [31:0]   reg_rd_data,
  output logic          wr_strobe,
  output logic          frame_done,
  output logic          frame_err
);

  typedef enum logic [1:0] {IDLE, CMD, DATA, WAIT_CS} state_t;

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   clk_prev_q, clk_prev_d;
  logic                   cs_prev_q, cs_prev_d;
  // Fills with ones after reset; edges are ignored until the chains hold
  // real samples, so a cs already low at release never looks like a fall.
  logic [SYNC_STAGES:0]   settle_q, settle_d;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [8:0]  cmd_q, cmd_d;
  logic [31:0] rx_q, rx_d;
  logic [31:0] tx_q, tx_d;
  logic        extra_q, extra_d;
  logic        wr_strobe_q, wr_strobe_d;
  logic        frame_done_q, frame_done_d;
  logic        frame_err_q, frame_err_d;
  logic [31:0] regs_q [NUM_REGS];

  logic        clk_s, cs_s, mosi_s, settled;
  logic        clk_rise, clk_fall, cs_rise, cs_fall;
  logic [8:0]  cmd_shift;
  logic [31:0] rx_shift;

  assign clk_s    = clk_sync_q[SYNC_STAGES-1];
  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign settled  = settle_q[SYNC_STAGES];
  assign clk_rise = settled &  clk_s & ~clk_prev_q;
  assign clk_fall = settled & ~clk_s &  clk_prev_q;
  assign cs_rise  = settled &  cs_s  & ~cs_prev_q;
  assign cs_fall  = settled & ~cs_s  &  cs_prev_q;

  assign cmd_shift = {cmd_q[7:0], mosi_s};
  assign rx_shift  = {rx_q[30:0], mosi_s};

  function automatic logic addr_ok(input logic [7:0] a);
    return ({24'd0, a} < 32'(NUM_REGS));
  endfunction

  // Synchronizer chains and edge-detect history
  always_comb begin
    clk_sync_d[0]  = spi_clk;
    cs_sync_d[0]   = spi_cs;
    mosi_sync_d[0] = spi_mosi;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      clk_sync_d[i]  = clk_sync_q[i-1];
      cs_sync_d[i]   = cs_sync_q[i-1];
      mosi_sync_d[i] = mosi_sync_q[i-1];
    end
    clk_prev_d = clk_s;
    cs_prev_d  = cs_s;
    settle_d   = {settle_q[SYNC_STAGES-1:0], 1'b1};
  end

  always_ff @(posedge SCLK or negedge SRESETn) begin
    if (!SRESETn) begin
      clk_sync_q  <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      clk_prev_q  <= 1'b0;
      cs_prev_q   <= 1'b1;
      settle_q    <= '0;
    end else begin
      clk_sync_q  <= clk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      clk_prev_q  <= clk_prev_d;
      cs_prev_q   <= cs_prev_d;
      settle_q    <= settle_d;
    end
  end

  // Frame FSM: next state, shift registers and one-cycle pulses
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cmd_d        = cmd_q;
    rx_d         = rx_q;
    tx_d         = tx_q;
    extra_d      = extra_q;
    wr_strobe_d  = 1'b0;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d = CMD;
          cnt_d   = '0;
          cmd_d   = '0;
          rx_d    = '0;
          tx_d    = '0;
          extra_d = 1'b0;
        end
      end
      CMD: begin
        if (cs_rise) begin
          frame_err_d = 1'b1;
          state_d     = IDLE;
        end else if (clk_rise) begin
          cmd_d = cmd_shift;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd8) begin
            state_d = DATA;
            // Reads present bit 31 before the next spi_clk fall
            if (!cmd_shift[8] && addr_ok(cmd_shift[7:0]))
              tx_d = regs_q[cmd_shift[AW-1:0]];
            else
              tx_d = '0;
          end
        end
      end
      DATA: begin
        if (cs_rise) begin
          frame_err_d = 1'b1;
          state_d     = IDLE;
        end else if (clk_rise) begin
          rx_d  = rx_shift;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd40) begin
            state_d      = WAIT_CS;
            frame_done_d = 1'b1;
            wr_strobe_d  = cmd_q[8] & addr_ok(cmd_q[7:0]);
          end
        end else if (clk_fall && cnt_q > 6'd9) begin
          // The fall right after the command keeps bit 31 on the line
          tx_d = {tx_q[30:0], 1'b0};
        end
      end
      WAIT_CS: begin
        if (cs_rise) begin
          frame_err_d = extra_q;
          state_d     = IDLE;
        end else if (clk_rise) begin
          extra_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge SCLK or negedge SRESETn) begin
    if (!SRESETn) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      cmd_q        <= '0;
      rx_q         <= '0;
      tx_q         <= '0;
      extra_q      <= 1'b0;
      wr_strobe_q  <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cmd_q        <= cmd_d;
      rx_q         <= rx_d;
      tx_q         <= tx_d;
      extra_q      <= extra_d;
      wr_strobe_q  <= wr_strobe_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // Register file: the SPI frame is the only writer
  always_ff @(posedge SCLK or negedge SRESETn) begin
    if (!SRESETn) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (wr_strobe_d) begin
      regs_q[cmd_q[AW-1:0]] <= rx_shift;
    end
  end

  assign spi_miso    = (state_q == DATA) & ~cmd_q[8] & ~cs_s & tx_q[31];
  assign reg_rd_data = regs_q[reg_rd_addr];
  assign wr_strobe   = wr_strobe_q;
  assign frame_done  = frame_done_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Directed bench: a bit-banged SPI master drives frames at SCLK/8, pulse
// monitors count output strobes, and a queue holds expected read values.
module tb_spi_slave_regfile;

  logic        SCLK = 1'b0;
  logic        SRESETn = 1'b0;
  logic        spi_clk = 1'b0;
  logic        spi_cs = 1'b1;
  logic        spi_mosi = 1'b0;
  logic        spi_miso;
  logic [3:0]  reg_rd_addr = '0;
  logic [31:0] reg_rd_data;
  logic        wr_strobe, frame_done, frame_err;

  spi_slave_regfile dut (
    .SCLK(SCLK), .SRESETn(SRESETn), .spi_clk(spi_clk), .spi_cs(spi_cs),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .reg_rd_addr(reg_rd_addr),
    .reg_rd_data(reg_rd_data), .wr_strobe(wr_strobe),
    .frame_done(frame_done), .frame_err(frame_err)
  );

  always #5 SCLK = ~SCLK;

  int n_tests = 0;
  int n_fail  = 0;
  int n_wr = 0, n_done = 0, n_err = 0;
  int b_wr, b_done, b_err;
  logic [31:0] model [16];

  typedef struct { string tag; logic [31:0] v; } exp_t;
  exp_t sb[$];

  // Count high cycles of each pulse output, sampled away from the active edge
  always @(negedge SCLK) begin
    if (wr_strobe)  n_wr++;
    if (frame_done) n_done++;
    if (frame_err)  n_err++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    sb.push_back(e);
  endtask

  task automatic sb_pop_check(input logic [31:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check(e.tag, obs, e.v);
    end
  endtask

  task automatic mark();
    b_wr = n_wr; b_done = n_done; b_err = n_err;
  endtask

  task automatic check_pulses(input string tag, input int ew, input int ed, input int ee);
    check({tag, "_wr"},   32'(n_wr - b_wr),     32'(ew));
    check({tag, "_done"}, 32'(n_done - b_done), 32'(ed));
    check({tag, "_err"},  32'(n_err - b_err),   32'(ee));
  endtask

  // Mode-0 master: mosi changes while spi_clk is low, miso sampled at rise.
  // rst_at >= 0 pulses SRESETn just before that bit's rising edge.
  task automatic spi_frame(input logic [40:0] word, input int nbits, input int rst_at,
                           output logic [31:0] rdata, output logic [8:0] cmd_miso);
    logic [42:0] cap;
    cap = '0;
    spi_cs = 1'b0;
    #200;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = (i < 41) ? word[40-i] : 1'b0;
      #40;
      if (i == rst_at) begin
        SRESETn = 1'b0;
        #20;
        check("rst_mid_outs", {28'd0, spi_miso, wr_strobe, frame_done, frame_err}, 32'd0);
        SRESETn = 1'b1;
        #10;
      end
      cap[i] = spi_miso;
      spi_clk = 1'b1;
      #40;
      spi_clk = 1'b0;
    end
    #100;
    spi_cs = 1'b1;
    spi_mosi = 1'b0;
    #200;
    for (int j = 0; j < 32; j++) rdata[31-j] = cap[9+j];
    for (int j = 0; j < 9; j++)  cmd_miso[8-j] = cap[j];
  endtask

  task automatic port_check(input string tag, input logic [3:0] a, input logic [31:0] v);
    sb_push(tag, v);
    reg_rd_addr = a;
    #10;
    sb_pop_check(reg_rd_data);
  endtask

  initial begin
    logic [31:0] rd;
    logic [8:0]  cm;
    logic [31:0] rv;
    for (int i = 0; i < 16; i++) model[i] = '0;

    // Reset state
    #23;
    check("rst_outs", {28'd0, spi_miso, wr_strobe, frame_done, frame_err}, 32'd0);
    port_check("rst_reg3", 4'd3, 32'd0);
    SRESETn = 1'b1;
    @(negedge SCLK);
    #100;

    // Write 0xA5A51234 to reg 3
    mark();
    spi_frame({1'b1, 8'h03, 32'hA5A5_1234}, 41, -1, rd, cm);
    model[3] = 32'hA5A5_1234;
    check_pulses("wr3", 1, 1, 0);
    check("wr3_miso", rd, 32'd0);
    port_check("wr3_reg", 4'd3, model[3]);

    // Read it back over SPI
    mark();
    sb_push("rd3_data", model[3]);
    spi_frame({1'b0, 8'h03, 32'h0}, 41, -1, rd, cm);
    sb_pop_check(rd);
    check("rd3_cmd_miso", {23'd0, cm}, 32'd0);
    check_pulses("rd3", 0, 1, 0);

    // Abort after 20 bits of a write to reg 5
    mark();
    spi_frame({1'b1, 8'h05, 32'hDEAD_BEEF}, 20, -1, rd, cm);
    check_pulses("abort5", 0, 0, 1);
    port_check("abort5_reg", 4'd5, 32'd0);

    // Out-of-range write leaves the file untouched; read returns zero
    mark();
    spi_frame({1'b1, 8'h12, 32'hFFFF_FFFF}, 41, -1, rd, cm);
    check_pulses("wr12", 0, 1, 0);
    for (int i = 0; i < 16; i++) port_check($sformatf("wr12_reg%0d", i), 4'(i), model[i]);
    mark();
    sb_push("rd12_data", 32'd0);
    spi_frame({1'b0, 8'h12, 32'h0}, 41, -1, rd, cm);
    sb_pop_check(rd);
    check_pulses("rd12", 0, 1, 0);

    // 43 clocks: frame completes, extra clocks flagged on cs rise
    mark();
    spi_frame({1'b1, 8'h00, 32'h0000_00FF}, 43, -1, rd, cm);
    model[0] = 32'h0000_00FF;
    check_pulses("wr0_x43", 1, 1, 1);
    port_check("wr0_reg", 4'd0, model[0]);

    // Random value to the top register, read back both ways
    rv = $urandom;
    mark();
    spi_frame({1'b1, 8'h0F, rv}, 41, -1, rd, cm);
    model[15] = rv;
    check_pulses("wr15", 1, 1, 0);
    sb_push("rd15_data", rv);
    spi_frame({1'b0, 8'h0F, 32'h0}, 41, -1, rd, cm);
    sb_pop_check(rd);
    port_check("wr15_reg", 4'd15, rv);

    // Reset during bit 30 of a write to reg 1
    mark();
    spi_frame({1'b1, 8'h01, 32'h1357_9BDF}, 41, 30, rd, cm);
    for (int i = 0; i < 16; i++) model[i] = '0;
    check_pulses("rstmid", 0, 0, 0);
    port_check("rstmid_reg1", 4'd1, 32'd0);
    port_check("rstmid_reg3", 4'd3, 32'd0);

    // Next full frame processes normally
    mark();
    spi_frame({1'b1, 8'h01, 32'h1234_5678}, 41, -1, rd, cm);
    model[1] = 32'h1234_5678;
    check_pulses("post_rst_wr1", 1, 1, 0);
    port_check("post_rst_reg1", 4'd1, model[1]);
    sb_push("post_rst_rd1", model[1]);
    spi_frame({1'b0, 8'h01, 32'h0}, 41, -1, rd, cm);
    sb_pop_check(rd);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
